// File: rtl/core_dmem_pkg.sv
// core_dmem shared definitions: access-size encodings, one-hot FSM states,
// store lane merge, load lane extraction/extension and alignment test.
package core_dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;  // 2'b11 also decodes as word

  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_RD     = 6'b000010;
  localparam logic [5:0] ST_WR     = 6'b000100;
  localparam logic [5:0] ST_RMW_RD = 6'b001000;
  localparam logic [5:0] ST_RMW_WR = 6'b010000;
  localparam logic [5:0] ST_RESP   = 6'b100000;

  // Replace the addressed lane of old_w with the same lane of the
  // lane-replicated store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = old_w;
    if (size[1]) begin
      r = wdata;
    end else if (size[0]) begin
      if (off[1]) r[31:16] = wdata[31:16];
      else        r[15:0]  = wdata[15:0];
    end else begin
      case (off)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[15:8];
        2'd2:    r[23:16] = wdata[23:16];
        default: r[31:24] = wdata[31:24];
      endcase
    end
    return r;
  endfunction

  // Pick the addressed lane of a RAM word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (size[1])      return word;
    else if (size[0]) return {{16{~uns & h[15]}}, h};
    else              return {{24{~uns & b[7]}}, b};
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size[1])      return off != 2'b00;
    else if (size[0]) return off[0];
    else              return 1'b0;
  endfunction

endpackage

// File: rtl/core_dmem_ram.sv
// Single-port word RAM, 2**DEPTH_LOG2 x 32, registered read (1-cycle
// latency), full-word write. Contents are not reset.
module core_dmem_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  CLK,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Read-first port: rdata always reflects the word before any same-cycle write.
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/core_dmem.sv
// core_dmem: data-memory responder for the multicycle core load/store port.
// One-hot FSM IDLE/RD/WR/RMW_RD/RMW_WR/RESP; sub-word stores are done as
// read-modify-write on the word RAM. Optional misalignment trapping is
// enabled by defining CORE_DMEM_ALIGN_CHECK_EN.
module core_dmem
  import core_dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        RST_N,
  input  logic        CLK,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_DATA,
  input  logic        MEM_WE,
  input  logic        MEM_RE,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_UNS,
  output logic [31:0] MEM_IN,
  output logic        MEM_READY,
  output logic        MEM_ERR
);

  localparam int AW = DEPTH_LOG2 + 2;

  logic [5:0]    state, state_nx;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic [1:0]    size_q;
  logic          uns_q, load_q;
  logic [31:0]   in_q, rdata, wdata, ld_val;
  logic          ram_we, req, accept, mis, err_cur, resp_load;

  // Upper address bits alias onto the RAM and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = &{1'b0, MEM_ADDR[31:AW]};

  assign req    = MEM_WE | MEM_RE;
  assign accept = (state == ST_IDLE) & req;

`ifdef CORE_DMEM_ALIGN_CHECK_EN
  logic err_q;
  assign mis     = misaligned(MEM_SIZE, MEM_ADDR[1:0]);
  assign err_cur = err_q;

  // Remember whether the accepted access was trapped as misaligned.
  always_ff @(posedge CLK) begin
    if (!RST_N)      err_q <= 1'b0;
    else if (accept) err_q <= mis;
  end
`else
  assign mis     = 1'b0;
  assign err_cur = 1'b0;
`endif

  // Next-state logic; stores win over loads when both are requested.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (mis)              state_nx = ST_RESP;
          else if (!MEM_WE)     state_nx = ST_RD;
          else if (MEM_SIZE[1]) state_nx = ST_WR;
          else                  state_nx = ST_RMW_RD;
        end
      end
      ST_RD, ST_WR, ST_RMW_WR: state_nx = ST_RESP;
      ST_RMW_RD:               state_nx = ST_RMW_WR;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight transaction.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Request capture at acceptance; inputs are ignored afterwards.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q <= MEM_ADDR[AW-1:0];
      data_q <= MEM_DATA;
      size_q <= MEM_SIZE;
      uns_q  <= MEM_UNS;
      load_q <= ~MEM_WE;
    end
  end

  assign ram_we = (state == ST_WR) | (state == ST_RMW_WR);
  assign wdata  = (state == ST_RMW_WR) ? lane_merge(rdata, data_q, size_q, addr_q[1:0]) : data_q;

  core_dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .CLK   (CLK),
    .addr  (addr_q[AW-1:2]),
    .we    (ram_we),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Read data lands in RESP; it is shown directly and held afterwards.
  assign ld_val    = load_extend(rdata, size_q, addr_q[1:0], uns_q);
  assign resp_load = (state == ST_RESP) & load_q & ~err_cur;

  // Hold register for the last completed load result.
  always_ff @(posedge CLK) begin
    if (!RST_N)         in_q <= '0;
    else if (resp_load) in_q <= ld_val;
  end

  assign MEM_IN    = resp_load ? ld_val : in_q;
  assign MEM_READY = (state == ST_RESP);
  assign MEM_ERR   = MEM_READY & err_cur;

endmodule

// File: tb/tb_core_dmem.sv
// Scoreboard bench for core_dmem: each request pushes its expected latency,
// MEM_IN and MEM_ERR; the response is popped and compared when READY rises.
module tb_core_dmem;

  localparam int DL2 = 10;

  logic        RST_N, CLK;
  logic [31:0] MEM_ADDR, MEM_DATA, MEM_IN;
  logic        MEM_WE, MEM_RE, MEM_UNS, MEM_READY, MEM_ERR;
  logic [1:0]  MEM_SIZE;

  core_dmem #(.DEPTH_LOG2(DL2)) dut (
    .RST_N(RST_N), .CLK(CLK), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_SIZE(MEM_SIZE), .MEM_UNS(MEM_UNS),
    .MEM_IN(MEM_IN), .MEM_READY(MEM_READY), .MEM_ERR(MEM_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          lat;
    logic [31:0] din;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Issue one request at a negedge, wait (bounded) for READY, score it.
  task automatic req(input string tag, input logic we, input logic re, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] data,
                     input int lat, input logic [31:0] exp_in, input logic exp_err);
    exp_t e;
    int   cnt;
    logic got;
    exp_q.push_back('{tag, lat, exp_in, exp_err});
    MEM_WE = we; MEM_RE = re; MEM_SIZE = sz; MEM_UNS = uns;
    MEM_ADDR = addr; MEM_DATA = data;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 8) begin
      @(posedge CLK); cnt++;
      @(negedge CLK);
      if (MEM_READY) got = 1'b1;
    end
    MEM_WE = 1'b0; MEM_RE = 1'b0;
    e = exp_q.pop_front();
    chk({e.tag, ".ready"}, {31'b0, got}, 32'd1);
    if (got) begin
      chk({e.tag, ".lat"}, 32'(cnt), 32'(e.lat));
      chk({e.tag, ".in"},  MEM_IN, e.din);
      chk({e.tag, ".err"}, {31'b0, MEM_ERR}, {31'b0, e.err});
    end
    @(posedge CLK); @(negedge CLK);
    chk({e.tag, ".pulse"}, {31'b0, MEM_READY}, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; MEM_WE = 1'b0; MEM_RE = 1'b0; MEM_SIZE = 2'b00; MEM_UNS = 1'b0;
    MEM_ADDR = '0; MEM_DATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst.in",    MEM_IN, 32'h0);
    chk("rst.ready", {31'b0, MEM_READY}, 32'd0);
    chk("rst.err",   {31'b0, MEM_ERR}, 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); @(negedge CLK);

    //   tag      we   re   size   uns   addr       data          lat in            err
    req("sw10",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h12345678, 2, 32'h00000000, 1'b0);
    req("lw10",  1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        2, 32'h12345678, 1'b0);
    req("sb11",  1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'hAAAAAAAA, 3, 32'h12345678, 1'b0);
    req("lw10b", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        2, 32'h1234AA78, 1'b0);
    req("lb11",  1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0,        2, 32'hFFFFFFAA, 1'b0);
    req("lbu11", 1'b0, 1'b1, 2'b00, 1'b1, 32'h11, 32'h0,        2, 32'h000000AA, 1'b0);
    req("sh12",  1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h80018001, 3, 32'h000000AA, 1'b0);
    req("lh12",  1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0,        2, 32'hFFFF8001, 1'b0);
    req("lhu12", 1'b0, 1'b1, 2'b01, 1'b1, 32'h12, 32'h0,        2, 32'h00008001, 1'b0);
    req("lw10c", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        2, 32'h8001AA78, 1'b0);
    req("sw00",  1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'hDEADBEEF, 2, 32'h8001AA78, 1'b0);
    req("alias", 1'b0, 1'b1, 2'b10, 1'b0, 32'(4 << DL2), 32'h0, 2, 32'hDEADBEEF, 1'b0);
    req("lb03",  1'b0, 1'b1, 2'b00, 1'b0, 32'h03, 32'h0,        2, 32'hFFFFFFDE, 1'b0);
    req("lbu00", 1'b0, 1'b1, 2'b00, 1'b1, 32'h00, 32'h0,        2, 32'h000000EF, 1'b0);
    req("lh00",  1'b0, 1'b1, 2'b01, 1'b0, 32'h00, 32'h0,        2, 32'hFFFFBEEF, 1'b0);
    req("both",  1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D, 2, 32'hFFFFBEEF, 1'b0);
    req("lw20",  1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0,        2, 32'hCAFEF00D, 1'b0);

    // Reset during RMW_RD: aborted, nothing written, outputs cleared.
    MEM_WE = 1'b1; MEM_SIZE = 2'b00; MEM_ADDR = 32'h11; MEM_DATA = 32'h55555555;
    @(posedge CLK); @(negedge CLK);
    RST_N = 1'b0; MEM_WE = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("mrst.in",    MEM_IN, 32'h0);
    chk("mrst.ready", {31'b0, MEM_READY}, 32'd0);
    chk("mrst.err",   {31'b0, MEM_ERR}, 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("mrst.idle",  {31'b0, MEM_READY}, 32'd0);
    req("mrst.lw",  1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h8001AA78, 1'b0);
    req("mrst.lbu", 1'b0, 1'b1, 2'b00, 1'b1, 32'h11, 32'h0, 2, 32'h000000AA, 1'b0);

`ifdef CORE_DMEM_ALIGN_CHECK_EN
    req("mis.lw13", 1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h0,        1, 32'h000000AA, 1'b1);
    req("mis.sw12", 1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 1, 32'h000000AA, 1'b1);
    req("mis.lh11", 1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0,        1, 32'h000000AA, 1'b1);
    req("mis.lw10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        2, 32'h8001AA78, 1'b0);
`else
    req("mis.lw13", 1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h0,        2, 32'h8001AA78, 1'b0);
    req("mis.lh13", 1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h0,        2, 32'hFFFF8001, 1'b0);
    req("mis.sw12", 1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 2, 32'hFFFF8001, 1'b0);
    req("mis.lw10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        2, 32'hFFFFFFFF, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
